bcd_to_bin_seq: RTL and testbench

Sequential BCD-to-binary decoder that converts a packed NDIG-digit BCD value (e.g. the ones/tens/hundreds score digits) into a plain binary integer.
- Binary result feeds comparators, thresholds and address arithmetic in the VGA display path.
- Works digit-serially, most significant digit first, using Horner evaluation: acc = acc*10 + digit.
- Start/busy/done handshake; latency is NDIG+1 cycles.

---
 rtl/bcd_to_bin_seq.sv | 89 ++++++++
 tb/tb_bcd_to_bin_seq.sv | 126 ++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// Digit-serial BCD-to-binary converter using Horner evaluation (acc = acc*10 + digit).
// The most significant digit is processed first. A start/busy/done handshake gives NDIG+1 cycles of latency.
module bcd_to_bin_seq #(
  parameter int NDIG = 3,
  parameter int BW   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              busy,
  output logic              done,
  output logic [BW-1:0]     bin_out,
  output logic              err
);

  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            state, state_nxt;
  logic [4*NDIG-1:0] sr;
  logic [BW-1:0]     acc, acc_nxt;
  logic [CW-1:0]     cnt;
  logic              err_acc, err_nxt;
  logic [3:0]        digit;

  // acc*10 + d as shift-and-add, modulo 2^BW
  function automatic logic [BW-1:0] horner_step(input logic [BW-1:0] a, input logic [3:0] d);
    return (a << 3) + (a << 1) + BW'(d);
  endfunction

  assign digit   = sr[4*NDIG-1 -: 4];
  assign acc_nxt = horner_step(acc, digit);
  assign err_nxt = err_acc | (digit > 4'd9);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Result registers update only on the final CONV edge, so they hold between conversions
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr      <= '0;
      acc     <= '0;
      cnt     <= '0;
      err_acc <= 1'b0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sr      <= bcd_in;
            acc     <= '0;
            cnt     <= '0;
            err_acc <= 1'b0;
          end
        end
        CONV: begin
          sr      <= sr << 4;
          acc     <= acc_nxt;
          cnt     <= cnt + 1'b1;
          err_acc <= err_nxt;
          if (cnt == CNT_LAST) begin
            bin_out <= err_nxt ? '0 : acc_nxt;
            err     <= err_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq (NDIG=3, BW=10) with hand-computed expected results.
module tb_bcd_to_bin_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [11:0] bcd_in;
  logic        busy;
  logic        done;
  logic [9:0]  bin_out;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] last_bin;
  logic       last_err;

  bcd_to_bin_seq #(.NDIG(3), .BW(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the next rising edge accepts start (cycle 0).
  task automatic do_conv(input logic [11:0] bcd, input logic [11:0] mid_bcd, input logic hold,
                         input logic [9:0] exp_bin, input logic exp_err, input string tag);
    start  = 1'b1;
    bcd_in = bcd;
    @(posedge clk);
    @(negedge clk);
    start  = hold;
    bcd_in = mid_bcd;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) @(negedge clk);
      chk({tag, "_busy_c", $sformatf("%0d", c)}, busy, 1);
      chk({tag, "_done_c", $sformatf("%0d", c)}, done, 0);
      chk({tag, "_hold_bin_c", $sformatf("%0d", c)}, bin_out, last_bin);
      chk({tag, "_hold_err_c", $sformatf("%0d", c)}, err, last_err);
    end
    @(negedge clk);
    chk({tag, "_busy_c4"}, busy, 1);
    chk({tag, "_done_c4"}, done, 1);
    chk({tag, "_bin"}, bin_out, exp_bin);
    chk({tag, "_err"}, err, exp_err);
    last_bin = exp_bin;
    last_err = exp_err;
    @(negedge clk);
    chk({tag, "_busy_c5"}, busy, 0);
    chk({tag, "_done_c5"}, done, 0);
    chk({tag, "_bin_c5"}, bin_out, exp_bin);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    bcd_in   = 12'h000;
    last_bin = 10'd0;
    last_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bin", bin_out, 0);
    chk("rst_err", err, 0);
    reset = 1'b1;

    do_conv(12'h000, 12'h000, 1'b0, 10'd0, 1'b0, "zero");

    do_conv(12'h999, 12'h999, 1'b0, 10'h3E7, 1'b0, "max");
    repeat (10) @(negedge clk);
    chk("max_held_bin", bin_out, 10'h3E7);
    chk("max_held_done", done, 0);

    do_conv(12'h407, 12'h123, 1'b0, 10'h197, 1'b0, "capture");

    do_conv(12'h9A5, 12'h9A5, 1'b0, 10'h000, 1'b1, "invalid");
    do_conv(12'h050, 12'h050, 1'b0, 10'h032, 1'b0, "after_inv");

    // start held high during conversion is ignored; it is accepted again in cycle 5
    do_conv(12'h012, 12'h888, 1'b1, 10'h00C, 1'b0, "ignore_start");
    do_conv(12'h888, 12'h888, 1'b0, 10'h378, 1'b0, "restart");

    start  = 1'b1;
    bcd_in = 12'h765;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_bin", bin_out, 0);
    chk("async_rst_err", err, 0);
    last_bin = 10'd0;
    last_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    do_conv(12'h001, 12'h001, 1'b0, 10'd1, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
